uart_tx_sched: RTL and testbench

Round-robin scheduler sharing the single UART transmitter (`wrsig`/`dataout` byte interface) among `N_REQ` byte-stream requesters: receive echo, measurement telemetry frames, and command responses. It grants the transmitter for one whole frame at a time, so frames never interleave. It paces bytes at a fixed spacing that covers one character time, and drops a stalled frame after a timeout. It sits between the requester blocks and the UART transmit module.

---
 rtl/dfm_uart_pkg.sv | 23 ++
 rtl/uart_rr_pick.sv | 46 ++++
 rtl/uart_tx_sched.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dfm_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dfm_uart_pkg
// Description : Shared types and default constants for the UART transmit
//               scheduler: FSM state encoding, byte width, default pacing
//               gap and default mid-frame stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package dfm_uart_pkg;

    localparam int BYTE_W             = 8;
    localparam int UART_BYTE_GAP      = 256;
    localparam int UART_FRAME_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        WAIT = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker. Finds the first asserted
//               bit of valid, searching upward from rr_ptr with wrap-around.
// Ports       : valid      - request vector
//               rr_ptr     - index searched first
//               sel_onehot - one-hot winner (0 when nothing valid)
//               sel_idx    - binary index of the winner
//               sel_any    - at least one request is valid
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick #(
    parameter int N_REQ = 3,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] sel_onehot,
    output logic [PTR_W-1:0] sel_idx,
    output logic             sel_any
);

    int w_pos;

    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        sel_any    = 1'b0;
        w_pos      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // rr_ptr < N_REQ always, so one subtraction is enough to wrap.
            w_pos = int'(rr_ptr) + k;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            if (!sel_any && valid[w_pos]) begin
                sel_any           = 1'b1;
                sel_onehot[w_pos] = 1'b1;
                sel_idx           = PTR_W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Round-robin scheduler sharing one UART transmitter among
//               N_REQ byte-stream requesters. Grants whole frames, paces
//               bytes BYTE_GAP clocks apart and drops a frame whose owner
//               stalls for FRAME_TIMEOUT clocks.
// Ports       : clk, rst (async, active high)
//               req_valid/req_data/req_last/req_ready - requester handshake
//               wrsig/dataout - strobe and byte to the UART transmitter
//               grant - one-hot frame owner, busy - not IDLE
//               timeout_err - one-cycle pulse when a frame is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import dfm_uart_pkg::*;
#(
    parameter int N_REQ         = 3,
    parameter int BYTE_GAP      = UART_BYTE_GAP,
    parameter int FRAME_TIMEOUT = UART_FRAME_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    wrsig,
    output logic [BYTE_W-1:0]       dataout,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int GAP_W = $clog2(BYTE_GAP);
    localparam int TO_W  = $clog2(FRAME_TIMEOUT + 1);

    // GAP lasts BYTE_GAP-2 cycles: counter runs 0 .. BYTE_GAP-3.
    localparam logic [GAP_W-1:0] C_GAP_END = GAP_W'(BYTE_GAP - 3);
    localparam logic [TO_W-1:0]  C_TO_END  = TO_W'(FRAME_TIMEOUT);

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_last_q;
    logic [BYTE_W-1:0]  r_dataout;
    logic [N_REQ-1:0]   r_grant;

    logic [N_REQ-1:0]   w_pick_sel;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [PTR_W-1:0]   w_idx;
    logic               w_accept;
    logic               w_gap_done;
    logic               w_timeout;
    logic               w_release;
    logic [PTR_W-1:0]   w_ptr_after_owner;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid      (req_valid),
        .rr_ptr     (r_rr_ptr),
        .sel_onehot (w_pick_sel),
        .sel_idx    (w_pick_idx),
        .sel_any    (w_pick_any)
    );

    assign w_gap_done        = (r_gap_cnt == C_GAP_END);
    assign w_timeout         = (r_state == WAIT) && (r_to_cnt == C_TO_END);
    // Frame ends either after the last byte's gap or on a dropped frame.
    assign w_release         = ((r_state == GAP) && w_gap_done && r_last_q) || w_timeout;
    assign w_ptr_after_owner = (int'(r_owner) == N_REQ - 1) ? '0 : r_owner + PTR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_idx       = r_owner;
        case (r_state)
            IDLE: begin
                req_ready = w_pick_sel;
                w_idx     = w_pick_idx;
                if (w_pick_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_state_nxt = GAP;
            end
            GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = r_last_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                // The timeout cycle refuses any byte so the drop is clean.
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                end else begin
                    req_ready[r_owner] = 1'b1;
                    if (req_valid[r_owner]) begin
                        w_accept    = 1'b1;
                        w_state_nxt = SEND;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
            r_last_q  <= 1'b0;
            r_dataout <= '0;
            r_grant   <= '0;
        end else begin
            if (w_accept) begin
                r_dataout <= req_data[int'(w_idx)*BYTE_W +: BYTE_W];
                r_last_q  <= req_last[w_idx];
                if (r_state == IDLE) begin
                    r_owner <= w_idx;
                    r_grant <= w_pick_sel;
                end
            end

            if (r_state == SEND) begin
                r_gap_cnt <= '0;
            end else if ((r_state == GAP) && !w_gap_done) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end

            // Counts only idle WAIT cycles; cleared everywhere else.
            if ((r_state == WAIT) && !w_timeout && !req_valid[r_owner]) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if (w_release) begin
                r_rr_ptr <= w_ptr_after_owner;
                r_grant  <= '0;
            end
        end
    end

    assign wrsig       = (r_state == SEND);
    assign dataout     = r_dataout;
    assign grant       = r_grant;
    assign busy        = (r_state != IDLE);
    assign timeout_err = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Self-checking bench for uart_tx_sched (3 requesters,
//               BYTE_GAP 256, FRAME_TIMEOUT 100). Requester sources are byte
//               queues; expected bytes/owners go to a scoreboard queue and
//               are compared at every wrsig pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        wrsig;
    logic [7:0]  dataout;
    logic [2:0]  grant;
    logic        busy;
    logic        timeout_err;

    uart_tx_sched #(
        .N_REQ         (3),
        .BYTE_GAP      (256),
        .FRAME_TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .wrsig       (wrsig),
        .dataout     (dataout),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          to_pulses = 0;
    int          to_cyc = -1;
    int          rdy2_cyc = -1;
    bit          watch_rdy2 = 1'b0;
    logic [8:0]  src0[$];   // {last, data}
    logic [8:0]  src1[$];
    logic [8:0]  src2[$];
    logic [10:0] exp_q[$];  // {grant, data}
    int          acc_q[$];  // accept cycle of each byte in flight
    int          wr_cyc[$]; // cycles with wrsig high

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_inputs();
        logic [8:0] t;
        t = (src0.size() != 0) ? src0[0] : 9'h000;
        req_valid[0] = (src0.size() != 0); req_data[7:0]   = t[7:0]; req_last[0] = t[8];
        t = (src1.size() != 0) ? src1[0] : 9'h000;
        req_valid[1] = (src1.size() != 0); req_data[15:8]  = t[7:0]; req_last[1] = t[8];
        t = (src2.size() != 0) ? src2[0] : 9'h000;
        req_valid[2] = (src2.size() != 0); req_data[23:16] = t[7:0]; req_last[2] = t[8];
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic [2:0] g);
        exp_q.push_back({g, d});
    endtask

    // One clock: observe at the falling edge, update sources after the rise.
    task automatic tick();
        logic [2:0]  acc;
        logic [8:0]  tmp;
        logic [10:0] e;
        int          a;
        @(negedge clk);
        acc = rst ? 3'b000 : (req_valid & req_ready);
        if (timeout_err) begin
            to_pulses++;
            to_cyc = cyc;
        end
        if (watch_rdy2 && (rdy2_cyc < 0) && req_ready[2] && !rst) rdy2_cyc = cyc;
        if (wrsig) begin
            wr_cyc.push_back(cyc);
            check("wr_pending", (exp_q.size() != 0 && acc_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0 && acc_q.size() != 0) begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("wr_data", {24'd0, dataout}, {24'd0, e[7:0]});
                check("wr_grant", {29'd0, grant}, {29'd0, e[10:8]});
                check("wr_latency", cyc, a + 1);
            end
        end
        if (acc != 3'b000) acc_q.push_back(cyc);
        @(posedge clk);
        cyc++;
        #1;
        if (acc[0]) tmp = src0.pop_front();
        if (acc[1]) tmp = src1.pop_front();
        if (acc[2]) tmp = src2.pop_front();
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_wr(input int n, input int budget);
        int g;
        g = 0;
        while (wr_cyc.size() < n && g < budget) begin
            tick();
            g++;
        end
        check("wr_count", wr_cyc.size(), n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wrsig"}, {31'd0, wrsig}, 32'd0);
        check({tag, "_dataout"}, {24'd0, dataout}, 32'd0);
        check({tag, "_grant"}, {29'd0, grant}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        int rel;
        int s;
        int g;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;

        // Reset state, then all three requesters valid at release.
        src0.push_back({1'b1, 8'h10}); src0.push_back({1'b1, 8'h10});
        src1.push_back({1'b1, 8'h11}); src1.push_back({1'b1, 8'h11});
        src2.push_back({1'b1, 8'h12});
        drive_inputs();
        run(3);
        check_reset_outputs("reset");
        expect_byte(8'h10, 3'b001); expect_byte(8'h11, 3'b010); expect_byte(8'h12, 3'b100);
        expect_byte(8'h10, 3'b001); expect_byte(8'h11, 3'b010);
        rst = 1'b0;
        rel = cyc;
        run_until_wr(5, 1400);
        check("rr_first_wr", wr_cyc[0], rel + 1);
        for (int k = 1; k < 5; k++) check("rr_spacing", wr_cyc[k] - wr_cyc[k-1], 256);
        run(260);

        // Single three-byte frame from requester 1.
        wr_cyc.delete();
        src1.push_back({1'b0, 8'h0A}); src1.push_back({1'b0, 8'h55}); src1.push_back({1'b1, 8'h0A});
        expect_byte(8'h0A, 3'b010); expect_byte(8'h55, 3'b010); expect_byte(8'h0A, 3'b010);
        drive_inputs();
        run_until_wr(3, 800);
        check("single_sp1", wr_cyc[1] - wr_cyc[0], 256);
        check("single_sp2", wr_cyc[2] - wr_cyc[1], 256);
        g = 0;
        while (busy && g < 400) begin
            tick();
            g++;
        end
        check("single_busy_drop", cyc, wr_cyc[2] + 255);
        check("single_grant_idle", {29'd0, grant}, 32'd0);

        // Frame lock: requester 2 arrives during requester 0's frame.
        wr_cyc.delete();
        src0.push_back({1'b0, 8'hA0}); src0.push_back({1'b0, 8'hA1});
        src0.push_back({1'b0, 8'hA2}); src0.push_back({1'b1, 8'hA3});
        expect_byte(8'hA0, 3'b001); expect_byte(8'hA1, 3'b001);
        expect_byte(8'hA2, 3'b001); expect_byte(8'hA3, 3'b001);
        drive_inputs();
        run_until_wr(2, 600);
        src2.push_back({1'b1, 8'hC2});
        expect_byte(8'hC2, 3'b100);
        drive_inputs();
        watch_rdy2 = 1'b1;
        rdy2_cyc = -1;
        run_until_wr(5, 1000);
        watch_rdy2 = 1'b0;
        check("lock_ready2", rdy2_cyc, wr_cyc[3] + 255);
        check("lock_next_wr", wr_cyc[4] - wr_cyc[3], 256);
        run(260);

        // Timeout: requester 1 stalls after one non-last byte.
        wr_cyc.delete();
        to_pulses = 0;
        to_cyc = -1;
        src1.push_back({1'b0, 8'h77});
        src2.push_back({1'b1, 8'h22});
        expect_byte(8'h77, 3'b010); expect_byte(8'h22, 3'b100);
        drive_inputs();
        run_until_wr(1, 300);
        s = wr_cyc[0];
        run_until_wr(2, 600);
        check("to_pulses", to_pulses, 1);
        check("to_cycle", to_cyc, s + 355);
        check("to_next_wr", wr_cyc[1], to_cyc + 2);
        run(260);

        // Reset mid-GAP, with the round-robin pointer away from 0.
        wr_cyc.delete();
        src1.push_back({1'b1, 8'h31});
        expect_byte(8'h31, 3'b010);
        drive_inputs();
        run_until_wr(1, 300);
        run(260);
        wr_cyc.delete();
        src2.push_back({1'b0, 8'h41}); src2.push_back({1'b1, 8'h42});
        expect_byte(8'h41, 3'b100);
        drive_inputs();
        run_until_wr(1, 300);
        run(49);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_gap");
        src0.delete(); src1.delete(); src2.delete();
        drive_inputs();
        run(3);
        check("rst_no_wr", wr_cyc.size(), 1);
        src0.push_back({1'b1, 8'h50}); src1.push_back({1'b1, 8'h51}); src2.push_back({1'b1, 8'h52});
        expect_byte(8'h50, 3'b001); expect_byte(8'h51, 3'b010); expect_byte(8'h52, 3'b100);
        drive_inputs();
        tick();
        wr_cyc.delete();
        rst = 1'b0;
        rel = cyc;
        run_until_wr(3, 900);
        check("rst_first_wr", wr_cyc[0], rel + 1);
        run(260);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
